// File: rtl/elevator_scan.sv
// SCAN elevator controller: holds a pending-request bitmap, sweeps in one direction
// while requests lie ahead, reverses otherwise, and models travel and door dwell time.
module elevator_scan #(
    parameter  int FLOORS      = 8,
    localparam int FW          = $clog2(FLOORS),
    parameter  int MOVE_CYCLES = 1,
    parameter  int DOOR_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [FW-1:0]     req_floor,
    output logic [FW-1:0]     cur_floor,
    output logic              direction,
    output logic              moving,
    output logic              door_open,
    output logic              arrive,
    output logic [FLOORS-1:0] pending,
    output logic              req_err
);

    localparam int MW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
    localparam int DW = $clog2(DOOR_CYCLES + 1);
    localparam logic [MW-1:0] MOVE_LAST = MW'(MOVE_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LOAD = DW'(DOOR_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

    state_t            state, state_n;
    logic [MW-1:0]     move_cnt, move_n;
    logic [DW-1:0]     door_cnt, door_n;
    logic [FW-1:0]     floor_n, step_floor;
    logic              dir_n, pick_dir, ahead_up, ahead_dn;
    logic              arrive_n, req_err_n, req_ok, served;
    logic [FLOORS-1:0] clear, set, pending_n;

    assign moving    = (state == S_MOVE);
    assign door_open = (state == S_DOOR);
    assign req_ok    = int'(req_floor) < FLOORS;

    // Keep the sweep direction while any request lies strictly ahead; otherwise turn around.
    always_comb begin
        ahead_up = 1'b0;
        ahead_dn = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (pending[i] && i > int'(cur_floor)) ahead_up = 1'b1;
            if (pending[i] && i < int'(cur_floor)) ahead_dn = 1'b1;
        end
        pick_dir = direction ? ahead_dn : !ahead_up;
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_n    = state;
        floor_n    = cur_floor;
        dir_n      = direction;
        move_n     = move_cnt;
        door_n     = door_cnt;
        arrive_n   = 1'b0;
        served     = 1'b0;
        clear      = '0;
        set        = '0;
        step_floor = direction ? cur_floor - FW'(1) : cur_floor + FW'(1);

        case (state)
            S_IDLE: begin
                if (req_valid && req_floor == cur_floor) begin
                    state_n  = S_DOOR;
                    door_n   = DOOR_LOAD;
                    arrive_n = 1'b1;
                    served   = 1'b1;
                end else if (|pending) begin
                    dir_n   = pick_dir;
                    state_n = S_MOVE;
                    move_n  = '0;
                end
            end
            S_MOVE: begin
                if (move_cnt == MOVE_LAST) begin
                    floor_n = step_floor;
                    move_n  = '0;
                    if (pending[step_floor]) begin
                        clear[step_floor] = 1'b1;
                        state_n  = S_DOOR;
                        door_n   = DOOR_LOAD;
                        arrive_n = 1'b1;
                        served   = req_valid && req_floor == step_floor;
                    end
                end else begin
                    move_n = move_cnt + MW'(1);
                end
            end
            S_DOOR: begin
                if (req_valid && req_floor == cur_floor) begin
                    door_n = DOOR_LOAD;
                    served = 1'b1;
                end else if (door_cnt == DW'(1)) begin
                    if (|pending) begin
                        dir_n   = pick_dir;
                        state_n = S_MOVE;
                        move_n  = '0;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    door_n = door_cnt - DW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (req_valid && req_ok && !served) set[req_floor] = 1'b1;
        pending_n = (pending & ~clear) | set;
        req_err_n = req_valid && !req_ok;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cur_floor <= '0;
            direction <= 1'b0;
            move_cnt  <= '0;
            door_cnt  <= '0;
            pending   <= '0;
            arrive    <= 1'b0;
            req_err   <= 1'b0;
        end else begin
            state     <= state_n;
            cur_floor <= floor_n;
            direction <= dir_n;
            move_cnt  <= move_n;
            door_cnt  <= door_n;
            pending   <= pending_n;
            arrive    <= arrive_n;
            req_err   <= req_err_n;
        end
    end

endmodule

// File: tb/tb_elevator_scan.sv
// Bench for elevator_scan: three configurations share one request stream and are
// compared every cycle against a behavioural SCAN model, plus directed scenario checks.
module tb_elevator_scan;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid = 1'b0;
    logic [2:0] req_floor = '0;

    logic [2:0] d_floor[3];
    logic       d_dir[3], d_moving[3], d_door[3], d_arrive[3], d_err[3];
    logic [7:0] pend_a, pend_b;
    logic [5:0] pend_c;

    int n_vec = 0;
    int n_err = 0;
    int arrive_log[$];

    always #5 clk = ~clk;

    elevator_scan #(.FLOORS(8), .MOVE_CYCLES(1), .DOOR_CYCLES(2)) u_a (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_floor(req_floor),
        .cur_floor(d_floor[0]), .direction(d_dir[0]), .moving(d_moving[0]),
        .door_open(d_door[0]), .arrive(d_arrive[0]), .pending(pend_a), .req_err(d_err[0]));

    elevator_scan #(.FLOORS(8), .MOVE_CYCLES(3), .DOOR_CYCLES(2)) u_b (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_floor(req_floor),
        .cur_floor(d_floor[1]), .direction(d_dir[1]), .moving(d_moving[1]),
        .door_open(d_door[1]), .arrive(d_arrive[1]), .pending(pend_b), .req_err(d_err[1]));

    elevator_scan #(.FLOORS(6), .MOVE_CYCLES(1), .DOOR_CYCLES(2)) u_c (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_floor(req_floor),
        .cur_floor(d_floor[2]), .direction(d_dir[2]), .moving(d_moving[2]),
        .door_open(d_door[2]), .arrive(d_arrive[2]), .pending(pend_c), .req_err(d_err[2]));

    // Reference model: the car is idle, travelling (cycles left to next floor) or dwelling.
    int         cfg_floors[3] = '{8, 8, 6};
    int         cfg_move[3]   = '{1, 3, 1};
    int         cfg_door[3]   = '{2, 2, 2};
    int         m_floor[3], m_mode[3], m_travel[3], m_dwell[3];
    bit         m_dir[3], m_arrive[3], m_err[3];
    bit [7:0]   m_pend[3];

    function automatic logic [7:0] get_pend(int k);
        if (k == 0) return pend_a;
        if (k == 1) return pend_b;
        return {2'b00, pend_c};
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit choose_dir(int k, bit [7:0] p);
        bit ahead = 0;
        for (int i = 0; i < cfg_floors[k]; i++)
            if (p[i] && (m_dir[k] ? i < m_floor[k] : i > m_floor[k])) ahead = 1;
        return ahead ? m_dir[k] : !m_dir[k];
    endfunction

    task automatic model_step(int k, bit v, int f, bit rst);
        bit [7:0] p;
        bit       served;
        if (rst) begin
            m_floor[k] = 0; m_dir[k] = 0; m_mode[k] = 0; m_pend[k] = '0;
            m_travel[k] = 0; m_dwell[k] = 0; m_arrive[k] = 0; m_err[k] = 0;
            return;
        end
        p = m_pend[k];
        served = 0;
        m_arrive[k] = 0;
        m_err[k] = v && f >= cfg_floors[k];
        case (m_mode[k])
            0: begin
                if (v && f == m_floor[k]) begin
                    m_mode[k] = 2; m_dwell[k] = cfg_door[k]; m_arrive[k] = 1; served = 1;
                end else if (p != 0) begin
                    m_dir[k] = choose_dir(k, p); m_mode[k] = 1; m_travel[k] = cfg_move[k];
                end
            end
            1: begin
                m_travel[k]--;
                if (m_travel[k] == 0) begin
                    m_floor[k] += m_dir[k] ? -1 : 1;
                    check($sformatf("u%0d.floor_range", k), 32'(m_floor[k] >= 0 && m_floor[k] < cfg_floors[k]), 32'd1);
                    if (p[m_floor[k]]) begin
                        m_pend[k][m_floor[k]] = 1'b0;
                        m_mode[k] = 2; m_dwell[k] = cfg_door[k]; m_arrive[k] = 1;
                        served = v && f == m_floor[k];
                    end else begin
                        m_travel[k] = cfg_move[k];
                    end
                end
            end
            default: begin
                if (v && f == m_floor[k]) begin
                    m_dwell[k] = cfg_door[k]; served = 1;
                end else if (m_dwell[k] == 1) begin
                    if (p != 0) begin
                        m_dir[k] = choose_dir(k, p); m_mode[k] = 1; m_travel[k] = cfg_move[k];
                    end else begin
                        m_mode[k] = 0;
                    end
                end else begin
                    m_dwell[k]--;
                end
            end
        endcase
        if (v && f < cfg_floors[k] && !served) m_pend[k][f] = 1'b1;
    endtask

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("u%0d.cur_floor", k), 32'(d_floor[k]), 32'(m_floor[k]));
            check($sformatf("u%0d.direction", k), 32'(d_dir[k]), 32'(m_dir[k]));
            check($sformatf("u%0d.moving", k), 32'(d_moving[k]), 32'(m_mode[k] == 1));
            check($sformatf("u%0d.door_open", k), 32'(d_door[k]), 32'(m_mode[k] == 2));
            check($sformatf("u%0d.arrive", k), 32'(d_arrive[k]), 32'(m_arrive[k]));
            check($sformatf("u%0d.pending", k), 32'(get_pend(k)), 32'(m_pend[k]));
            check($sformatf("u%0d.req_err", k), 32'(d_err[k]), 32'(m_err[k]));
        end
    endtask

    task automatic tick(bit v, int f, bit rst);
        @(negedge clk);
        reset = rst;
        req_valid = v;
        req_floor = 3'(f);
        for (int k = 0; k < 3; k++) model_step(k, v, f, rst);
        @(posedge clk);
        #1;
        compare_all();
        if (d_arrive[0] === 1'b1) arrive_log.push_back(int'(d_floor[0]));
    endtask

    task automatic run(int n);
        repeat (n) tick(0, 0, 0);
    endtask

    initial begin
        bit sent;
        int exp_stops[4] = '{2, 5, 6, 1};

        // Reset state and single trip 0 -> 3
        tick(0, 0, 1);
        check("rst_floor", 32'(d_floor[0]), 0);
        check("rst_pending", 32'(pend_a), 0);
        tick(1, 3, 0);
        check("t1_pending", 32'(pend_a), 32'h08);
        for (int fl = 0; fl < 3; fl++) begin
            tick(0, 0, 0);
            check("t1_moving", 32'(d_moving[0]), 1);
            check("t1_floor", 32'(d_floor[0]), 32'(fl));
        end
        tick(0, 0, 0);
        check("t1_arrive", 32'(d_arrive[0]), 1);
        check("t1_at3", 32'(d_floor[0]), 3);
        check("t1_door", 32'(d_door[0]), 1);
        check("t1_pend0", 32'(pend_a), 0);
        tick(0, 0, 0);
        check("t1_door2", 32'(d_door[0]), 1);
        tick(0, 0, 0);
        check("t1_closed", 32'(d_door[0]), 0);
        check("t1_idle", 32'(d_moving[0]), 0);

        // SCAN ordering: stops 2, 5, 6 going up, then 1 going down
        tick(0, 0, 1);
        arrive_log.delete();
        tick(1, 6, 0);
        tick(1, 2, 0);
        tick(1, 5, 0);
        sent = 0;
        for (int i = 0; i < 40; i++) begin
            if (!sent && m_floor[0] == 3) begin
                tick(1, 1, 0);
                sent = 1;
            end else begin
                tick(0, 0, 0);
            end
        end
        check("t2_stop_count", 32'(arrive_log.size()), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t2_stop%0d", i), 32'(i < arrive_log.size() ? arrive_log[i] : -1), 32'(exp_stops[i]));
        check("t2_dir_down", 32'(d_dir[0]), 1);
        check("t2_floor1", 32'(d_floor[0]), 1);

        // Door at current floor and dwell retrigger
        tick(1, 4, 0);
        run(20);
        check("t3_at4", 32'(d_floor[0]), 4);
        tick(1, 4, 0);
        check("t3_arrive", 32'(d_arrive[0]), 1);
        check("t3_no_move", 32'(d_moving[0]), 0);
        check("t3_door", 32'(d_door[0]), 1);
        tick(0, 0, 0);
        tick(1, 4, 0);
        check("t3_retrig", 32'(d_door[0]), 1);
        check("t3_pend", 32'(pend_a), 0);
        tick(0, 0, 0);
        check("t3_extended", 32'(d_door[0]), 1);
        tick(0, 0, 0);
        check("t3_closed", 32'(d_door[0]), 0);
        run(20);

        // Out-of-range request on the 6-floor car
        check("t4_pend_before", 32'(pend_c), 0);
        tick(1, 7, 0);
        check("t4_err", 32'(d_err[2]), 1);
        check("t4_pend_same", 32'(pend_c), 0);
        check("t4_still_idle", 32'(d_moving[2]), 0);
        tick(0, 0, 0);
        check("t4_err_pulse", 32'(d_err[2]), 0);
        tick(1, 5, 0);
        check("t4_accept5", 32'(pend_c), 32'h20);
        check("t4_no_err", 32'(d_err[2]), 0);
        run(20);

        // Top floor, reversal without wrap, request at the top while there
        tick(0, 0, 1);
        tick(1, 7, 0);
        run(20);
        check("t5_top", 32'(d_floor[0]), 7);
        check("t5_dir_up", 32'(d_dir[0]), 0);
        tick(1, 0, 0);
        check("t5_pend0", 32'(pend_a), 32'h01);
        tick(0, 0, 0);
        check("t5_dir_flip", 32'(d_dir[0]), 1);
        check("t5_moving", 32'(d_moving[0]), 1);
        run(20);
        check("t5_bottom", 32'(d_floor[0]), 0);
        tick(0, 0, 1);
        tick(1, 7, 0);
        run(20);
        tick(1, 7, 0);
        check("t5_top_door", 32'(d_door[0]), 1);
        check("t5_top_arrive", 32'(d_arrive[0]), 1);
        check("t5_top_pend", 32'(pend_a), 0);
        run(5);

        // Reset while the slow car is mid-move with floors 5 and 7 pending
        tick(0, 0, 1);
        tick(1, 5, 0);
        tick(1, 7, 0);
        tick(0, 0, 0);
        check("t6_pend_a0", 32'(pend_b), 32'hA0);
        check("t6_moving", 32'(d_moving[1]), 1);
        tick(0, 0, 1);
        check("t6_floor", 32'(d_floor[1]), 0);
        check("t6_pend", 32'(pend_b), 0);
        check("t6_moving0", 32'(d_moving[1]), 0);
        check("t6_door0", 32'(d_door[1]), 0);
        check("t6_dir0", 32'(d_dir[1]), 0);
        tick(0, 0, 0);
        check("t6_no_arrive", 32'(d_arrive[1]), 0);

        // Random request stream with occasional resets
        for (int i = 0; i < 3000; i++)
            tick(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom_range(0, 299) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
